// File: rtl/video_sync_to_axi4s.sv
// Raw video timing (vsync/DE/pixel) to AXI4-Stream video with tuser/tlast framing.
// Also measures frame geometry and flags mismatches against the expected size.
module video_sync_to_axi4s #(
  parameter int COMPONENTS     = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int H_BITS         = 12,
  parameter int V_BITS         = 12,
  parameter int FC_BITS        = 16,
  parameter int VSYNC_POLARITY = 1
) (
  input  logic                             reset,
  input  logic                             clk,
  input  logic                             cke,
  input  logic [H_BITS-1:0]                param_width,
  input  logic [V_BITS-1:0]                param_height,
  input  logic                             in_vsync,
  input  logic                             in_de,
  input  logic [COMPONENTS*DATA_WIDTH-1:0] in_data,
  output logic                             m_axi4s_tuser,
  output logic                             m_axi4s_tlast,
  output logic [COMPONENTS*DATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                             m_axi4s_tvalid,
  input  logic                             m_axi4s_tready,
  output logic                             frame_done,
  output logic [FC_BITS-1:0]               frame_count,
  output logic [H_BITS-1:0]                meas_width,
  output logic [V_BITS-1:0]                meas_height,
  output logic                             err_width,
  output logic                             err_height,
  output logic                             err_overflow
);

  localparam int DW = COMPONENTS * DATA_WIDTH;

  typedef enum logic [1:0] {WAIT_VS, ARMED, ACTIVE} state_t;

  state_t            state, eff_state, next_state;
  logic              vs_q, de1, end_pend;
  logic [DW-1:0]     data1;
  logic [H_BITS-1:0] x_cnt, x_nxt, first_w, first_w_nxt, line_w;
  logic [V_BITS-1:0] y_cnt, y_nxt, y_base;
  logic              w_mixed, mixed_nxt, mix_base;
  logic              vs_act, vs_edge, emit, last_d, end_req, frame_end;

  function automatic logic [H_BITS-1:0] inc_h(input logic [H_BITS-1:0] v);
    return (&v) ? v : v + H_BITS'(1);
  endfunction

  function automatic logic [V_BITS-1:0] inc_v(input logic [V_BITS-1:0] v);
    return (&v) ? v : v + V_BITS'(1);
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    vs_act    = (VSYNC_POLARITY != 0) ? in_vsync : ~in_vsync;
    vs_edge   = vs_act & ~vs_q;
    emit      = de1 & (state != WAIT_VS);
    last_d    = emit & (~in_de | vs_edge);
    // A pixel leaving ARMED makes the frame active before vsync is considered.
    eff_state = (state == ARMED && de1) ? ACTIVE : state;
    if (state == WAIT_VS) next_state = vs_edge ? ARMED : WAIT_VS;
    else                  next_state = vs_edge ? ARMED : eff_state;
    end_req   = vs_edge & (eff_state == ACTIVE);
    frame_end = end_pend & (y_cnt != '0);

    line_w      = inc_h(x_cnt);
    y_base      = frame_end ? '0 : y_cnt;
    mix_base    = frame_end ? 1'b0 : w_mixed;
    x_nxt       = x_cnt;
    y_nxt       = y_base;
    first_w_nxt = first_w;
    mixed_nxt   = mix_base;
    if (emit) begin
      if (last_d) begin
        x_nxt = '0;
        y_nxt = inc_v(y_base);
        // Width consistency is tracked per frame and compared to param_width at frame end.
        if (y_base == '0) begin
          first_w_nxt = line_w;
          mixed_nxt   = 1'b0;
        end else begin
          mixed_nxt = mix_base | (line_w != first_w);
        end
      end else begin
        x_nxt = line_w;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= WAIT_VS;
      vs_q           <= 1'b0;
      de1            <= 1'b0;
      data1          <= '0;
      end_pend       <= 1'b0;
      x_cnt          <= '0;
      y_cnt          <= '0;
      first_w        <= '0;
      w_mixed        <= 1'b0;
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tuser  <= 1'b0;
      m_axi4s_tlast  <= 1'b0;
      m_axi4s_tdata  <= '0;
      frame_done     <= 1'b0;
      frame_count    <= '0;
      meas_width     <= '0;
      meas_height    <= '0;
      err_width      <= 1'b0;
      err_height     <= 1'b0;
      err_overflow   <= 1'b0;
    end else if (cke) begin
      state          <= next_state;
      vs_q           <= vs_act;
      de1            <= in_de;
      data1          <= in_data;
      end_pend       <= end_req;
      x_cnt          <= x_nxt;
      y_cnt          <= y_nxt;
      first_w        <= first_w_nxt;
      w_mixed        <= mixed_nxt;
      m_axi4s_tvalid <= emit;
      m_axi4s_tuser  <= emit & (state == ARMED);
      m_axi4s_tlast  <= last_d;
      m_axi4s_tdata  <= emit ? data1 : '0;
      frame_done     <= frame_end;
      // Video cannot be stalled: a beat the sink refuses is lost and remembered.
      err_overflow   <= err_overflow | (m_axi4s_tvalid & ~m_axi4s_tready);
      if (last_d) meas_width <= line_w;
      if (frame_end) begin
        meas_height <= y_cnt;
        err_height  <= (y_cnt != param_height);
        err_width   <= w_mixed | (first_w != param_width);
        frame_count <= frame_count + FC_BITS'(1);
      end
    end
  end

endmodule
